// File: rtl/pwm_ramp.sv
// ============================================================================
//  Module      : pwm_ramp
//  Description : Duty-cycle ramp generator feeding a 256-level PWM. Accepts a
//                target duty and a frames-per-step rate over valid/ready and
//                walks the duty by +/-1 only on PWM frame boundaries.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_ramp #(
  parameter logic [7:0] INIT   = 8'd0,
  parameter int         RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [7:0]        tgt_data,
  input  logic [RATE_W-1:0] rate,
  output logic [7:0]        d_out,
  output logic              busy,
  output logic              done,
  output logic              frame_tick
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_fcnt;
  logic [7:0]        r_d;
  logic [7:0]        w_d_nxt;
  logic [7:0]        r_tgt;
  logic [7:0]        w_tgt_nxt;
  logic [RATE_W-1:0] r_rate;
  logic [RATE_W-1:0] w_rate_nxt;
  logic [RATE_W-1:0] r_pcnt;
  logic [RATE_W-1:0] w_pcnt_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_frame_tick;
  logic              w_accept;
  logic              w_last_frame;

  // Frame boundary: the PWM counter is at its last count, so a duty update on
  // this edge takes effect exactly when the next frame starts.
  assign w_frame_tick = (r_fcnt == 8'hFF);
  assign w_accept     = tgt_valid && (r_state == IDLE);
  assign w_last_frame = (r_pcnt == (r_rate - RATE_W'(1)));

  assign tgt_ready  = (r_state == IDLE);
  assign busy       = (r_state == RAMP);
  assign done       = r_done;
  assign d_out      = r_d;
  assign frame_tick = w_frame_tick;

  // Free-running frame counter, phase-aligned with the PWM via the shared reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt <= 8'd0;
    end else begin
      r_fcnt <= r_fcnt + 8'd1;
    end
  end

  // Next-state and datapath update for the IDLE/RAMP controller.
  always_comb begin
    w_state_nxt = r_state;
    w_d_nxt     = r_d;
    w_tgt_nxt   = r_tgt;
    w_rate_nxt  = r_rate;
    w_pcnt_nxt  = r_pcnt;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_tgt_nxt  = tgt_data;
          // A zero rate would never match pcnt==rate-1 sensibly; run it as 1.
          w_rate_nxt = (rate == '0) ? RATE_W'(1) : rate;
          w_pcnt_nxt = '0;
          if (tgt_data == r_d) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = RAMP;
          end
        end
      end
      RAMP: begin
        if (w_frame_tick) begin
          if (w_last_frame) begin
            w_pcnt_nxt = '0;
            // In RAMP r_d never equals r_tgt, so the step cannot overshoot or wrap.
            w_d_nxt = (r_tgt > r_d) ? (r_d + 8'd1) : (r_d - 8'd1);
            if (w_d_nxt == r_tgt) begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_pcnt_nxt = r_pcnt + RATE_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Controller state and datapath registers; reset discards any in-flight ramp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_d     <= INIT;
      r_tgt   <= INIT;
      r_rate  <= RATE_W'(1);
      r_pcnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_d     <= w_d_nxt;
      r_tgt   <= w_tgt_nxt;
      r_rate  <= w_rate_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_ramp.sv
// ============================================================================
//  Module      : tb_pwm_ramp
//  Description : Scoreboard bench for pwm_ramp. Each accepted request is
//                expanded into its expected duty-change events (clock edge,
//                value, done flag) from the frame/rate arithmetic; a monitor
//                pops and compares whenever d_out changes or done pulses.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pwm_ramp;

  logic       clk;
  logic       rst_n;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [7:0] tgt_data;
  logic [7:0] rate;
  logic [7:0] d_out;
  logic       busy;
  logic       done;
  logic       frame_tick;

  pwm_ramp #(.INIT(8'd0), .RATE_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .tgt_data   (tgt_data),
    .rate       (rate),
    .d_out      (d_out),
    .busy       (busy),
    .done       (done),
    .frame_tick (frame_tick)
  );

  typedef struct {
    int         edge_n;
    logic [7:0] d;
    bit         fin;
  } ev_t;

  ev_t        q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc;
  logic [7:0] dm;
  logic [7:0] prev_d;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; edge n sees fcnt == n mod 256.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc = 0;
    else        cyc = cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: expand a request accepted on edge a into expected events.
  task automatic model_accept(input int a, input logic [7:0] t, input logic [7:0] r);
    int rq, t1, steps, e;
    ev_t ev;
    rq = (r == 0) ? 1 : int'(r);
    if (t == dm) begin
      ev.edge_n = a; ev.d = dm; ev.fin = 1'b1;
      q.push_back(ev);
    end else begin
      t1 = a - (a % 256) + 255;
      if (t1 <= a) t1 += 256;
      steps = (t > dm) ? int'(t) - int'(dm) : int'(dm) - int'(t);
      for (int k = 1; k <= steps; k++) begin
        e = t1 + (k * rq - 1) * 256;
        ev.edge_n = e;
        ev.d      = (t > dm) ? 8'(int'(dm) + k) : 8'(int'(dm) - k);
        ev.fin    = (k == steps);
        q.push_back(ev);
      end
    end
    dm = t;
  endtask

  // Monitor: any duty change or done pulse must match the head of the queue.
  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) begin
      prev_d = d_out;
    end else begin
      if ((d_out !== prev_d) || done) begin
        if (q.size() == 0) begin
          chk("unexpected_event_d", int'(d_out), int'(prev_d));
        end else begin
          e = q.pop_front();
          chk("event_edge", cyc - 1, e.edge_n);
          chk("event_d", int'(d_out), int'(e.d));
          chk("event_done", int'(done), int'(e.fin));
          chk("event_busy", int'(busy), int'(!e.fin));
          if (e.fin) chk("event_ready", int'(tgt_ready), 1);
        end
      end
      prev_d = d_out;
    end
  end

  // Present a request (caller is at a negedge) and hold it until accepted.
  task automatic send(input logic [7:0] t, input logic [7:0] r);
    int n;
    logic [7:0] d0;
    tgt_valid = 1'b1; tgt_data = t; rate = r;
    n = 0;
    while (!tgt_ready && n < 20000) begin
      @(negedge clk); n++;
    end
    chk("accept_timeout", int'(tgt_ready), 1);
    d0 = dm;
    model_accept(cyc, t, r);
    @(negedge clk);
    tgt_valid = 1'b0;
    tgt_data  = $urandom_range(0, 255);
    rate      = $urandom_range(0, 255);
    chk("post_accept_busy", int'(busy), int'(t != d0));
    chk("post_accept_ready", int'(tgt_ready), int'(t == d0));
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (q.size() != 0 && n < bound) begin
      @(negedge clk); n++;
    end
    chk("idle_timeout_pending", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_tick, second_tick, n;
    logic [7:0] t;
    int delta;
    rst_n = 1'b0; tgt_valid = 1'b0; tgt_data = 8'd0; rate = 8'd0;
    dm = 8'd0; prev_d = 8'd0;
    first_tick = -1; second_tick = -1;

    // 1: reset values while held, then frame_tick phase after release.
    repeat (3) @(negedge clk);
    chk("rst_d_out", int'(d_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(tgt_ready), 1);
    rst_n = 1'b1;
    for (int i = 0; i < 520; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        if (first_tick < 0) first_tick = cyc;
        else if (second_tick < 0) second_tick = cyc;
      end
    end
    chk("first_frame_tick", first_tick, 255);
    chk("second_frame_tick", second_tick, 511);

    // 2: ramp up 0->3 at rate 1.
    send(8'd3, 8'd1);
    wait_idle(2000);
    chk("ramp_up_final", int'(d_out), 3);

    // 3: ramp down 3->0 at rate 2.
    send(8'd0, 8'd2);
    wait_idle(4000);
    chk("ramp_down_final", int'(d_out), 0);

    // 4a: rate 0 behaves as rate 1; 4b: no-op target.
    send(8'd1, 8'd0);
    wait_idle(1000);
    send(8'd1, 8'd3);
    wait_idle(10);
    chk("noop_d_out", int'(d_out), 1);

    // 5: back-pressure during a 0->2 ramp.
    send(8'd0, 8'd1);
    wait_idle(1000);
    send(8'd2, 8'd1);
    tgt_valid = 1'b1; tgt_data = 8'd200; rate = 8'd1;
    @(negedge clk);
    chk("backpressure_ready", int'(tgt_ready), 0);
    send(8'd200, 8'd1);

    // 6: asynchronous reset mid-ramp at d_out == 5.
    n = 0;
    while (d_out != 8'd5 && n < 3000) begin
      @(negedge clk); n++;
    end
    chk("reach_5", int'(d_out), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_d_out", int'(d_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(tgt_ready), 1);
    q.delete();
    dm = 8'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    chk("post_rst_d_out", int'(d_out), 0);
    chk("post_rst_busy", int'(busy), 0);

    // Random requests: small moves around the current duty, random phase/rate.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 300)) @(negedge clk);
      delta = int'($urandom_range(0, 8)) - 4;
      if (int'(dm) + delta < 0) t = 8'd0;
      else if (int'(dm) + delta > 255) t = 8'd255;
      else t = 8'(int'(dm) + delta);
      send(t, 8'($urandom_range(0, 3)));
      wait_idle(5000);
      chk("rand_final", int'(d_out), int'(dm));
    end

    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
